// File: rtl/decode_stage.sv
// RV32I decode stage: register file, bypass, immediate generation, and a
// single output pipeline register with valid/ready handshakes, stall and flush.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   f_valid/f_pc/f_instr    fetched instruction in; d_ready back to fetch
//   flush                   kill held and incoming instruction
//   wb_en/wb_reg/wb_data    register file write port from writeback
//   a_ready                 ALU stage accepts d_* this cycle
//   d_valid .. d_illegal    registered decoded instruction to the ALU stage
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int BYPASS_EN = 1,
    localparam int RW       = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            f_valid,
    input  logic [XLEN-1:0] f_pc,
    input  logic [31:0]     f_instr,
    output logic            d_ready,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [RW-1:0]   wb_reg,
    input  logic [XLEN-1:0] wb_data,
    input  logic            a_ready,
    output logic            d_valid,
    output logic [XLEN-1:0] d_pc,
    output logic [6:0]      d_opcode,
    output logic [3:0]      d_op,
    output logic [RW-1:0]   d_regA,
    output logic [RW-1:0]   d_regB,
    output logic [RW-1:0]   d_regD,
    output logic [XLEN-1:0] d_dataA,
    output logic [XLEN-1:0] d_dataB,
    output logic [XLEN-1:0] d_imm,
    output logic            d_w_en,
    output logic            d_illegal
);

    logic [XLEN-1:0]        r_rf [NREGS];

    logic                   r_valid;
    logic [XLEN-1:0]        r_pc;
    logic [6:0]             r_opcode;
    logic [3:0]             r_op;
    logic [RW-1:0]          r_rega;
    logic [RW-1:0]          r_regb;
    logic [RW-1:0]          r_regd;
    logic [XLEN-1:0]        r_da;
    logic [XLEN-1:0]        r_db;
    logic [XLEN-1:0]        r_imm;
    logic                   r_wen;
    logic                   r_ill;

    logic [6:0]             w_opc;
    logic [2:0]             w_f3;
    logic [RW-1:0]          w_rs1;
    logic [RW-1:0]          w_rs2;
    logic [RW-1:0]          w_rd;
    logic signed [31:0]     w_i32;
    logic signed [XLEN-1:0] w_imm;
    logic [3:0]             w_op;
    logic                   w_wen;
    logic                   w_ill;
    logic [XLEN-1:0]        w_da;
    logic [XLEN-1:0]        w_db;
    logic                   w_cap;
    logic                   w_wb;

    assign w_opc = f_instr[6:0];
    assign w_f3  = f_instr[14:12];
    assign w_rd  = f_instr[7 +: RW];
    assign w_rs1 = f_instr[15 +: RW];
    assign w_rs2 = f_instr[20 +: RW];

    assign d_ready = !r_valid || a_ready;
    assign w_cap   = f_valid && d_ready && !flush;
    assign w_wb    = wb_en && (wb_reg != '0);

    always_comb begin
        w_i32 = '0;
        w_op  = '0;
        w_wen = 1'b0;
        w_ill = 1'b0;
        case (w_opc)
            7'b0000011, 7'b1100111: begin
                w_i32 = {{20{f_instr[31]}}, f_instr[31:20]};
                w_wen = 1'b1;
            end
            7'b0010011: begin
                w_i32 = {{20{f_instr[31]}}, f_instr[31:20]};
                // Only the shift-right pair uses bit 30 to pick SRA vs SRL
                w_op  = {(w_f3 == 3'b101) ? f_instr[30] : 1'b0, w_f3};
                w_wen = 1'b1;
            end
            7'b0100011: begin
                w_i32 = {{20{f_instr[31]}}, f_instr[31:25], f_instr[11:7]};
            end
            7'b1100011: begin
                w_i32 = {{20{f_instr[31]}}, f_instr[7], f_instr[30:25],
                         f_instr[11:8], 1'b0};
                w_op  = {1'b0, w_f3};
            end
            7'b0110111, 7'b0010111: begin
                w_i32 = {f_instr[31:12], 12'b0};
                w_wen = 1'b1;
            end
            7'b0110011: begin
                w_op  = {f_instr[30], w_f3};
                w_wen = 1'b1;
            end
            7'b1101111: begin
                w_i32 = {{12{f_instr[31]}}, f_instr[19:12], f_instr[20],
                         f_instr[30:21], 1'b0};
                w_wen = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
        w_imm = w_i32;
    end

    // Register reads; writeback in the same cycle wins when bypassing
    always_comb begin
        w_da = '0;
        w_db = '0;
        if (w_rs1 != '0) begin
            if (BYPASS_EN != 0 && wb_en && wb_reg == w_rs1) w_da = wb_data;
            else w_da = r_rf[w_rs1];
        end
        if (w_rs2 != '0) begin
            if (BYPASS_EN != 0 && wb_en && wb_reg == w_rs2) w_db = wb_data;
            else w_db = r_rf[w_rs2];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else if (w_wb) begin
            r_rf[wb_reg] <= wb_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_opcode <= '0;
            r_op     <= '0;
            r_rega   <= '0;
            r_regb   <= '0;
            r_regd   <= '0;
            r_da     <= '0;
            r_db     <= '0;
            r_imm    <= '0;
            r_wen    <= 1'b0;
            r_ill    <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_cap) begin
            r_valid  <= 1'b1;
            r_pc     <= f_pc;
            r_opcode <= w_opc;
            r_op     <= w_op;
            r_rega   <= w_rs1;
            r_regb   <= w_rs2;
            r_regd   <= w_rd;
            r_da     <= w_da;
            r_db     <= w_db;
            r_imm    <= w_imm;
            r_wen    <= w_wen && (w_rd != '0);
            r_ill    <= w_ill;
        end else if (r_valid && a_ready) begin
            r_valid <= 1'b0;
        end else if (r_valid && BYPASS_EN != 0 && w_wb) begin
            // Stalled: keep held operands current with writeback
            if (wb_reg == r_rega) r_da <= wb_data;
            if (wb_reg == r_regb) r_db <= wb_data;
        end
    end

    assign d_valid   = r_valid;
    assign d_pc      = r_pc;
    assign d_opcode  = r_opcode;
    assign d_op      = r_op;
    assign d_regA    = r_rega;
    assign d_regB    = r_regb;
    assign d_regD    = r_regd;
    assign d_dataA   = r_da;
    assign d_dataB   = r_db;
    assign d_imm     = r_imm;
    assign d_w_en    = r_wen;
    assign d_illegal = r_ill;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed vectors with literal expectations plus
// a behavioural model compared against the bypassing instance every cycle.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        a_ready;

    logic        d_ready, d_valid, d_w_en, d_illegal;
    logic [31:0] d_pc, d_dataA, d_dataB, d_imm;
    logic [6:0]  d_opcode;
    logic [3:0]  d_op;
    logic [4:0]  d_regA, d_regB, d_regD;

    logic        n_ready, n_valid, n_w_en, n_illegal;
    logic [31:0] n_pc, n_dataA, n_dataB, n_imm;
    logic [6:0]  n_opcode;
    logic [3:0]  n_op;
    logic [4:0]  n_regA, n_regB, n_regD;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    decode_stage #(.XLEN(32), .NREGS(32), .BYPASS_EN(1)) u_dut (
        .clock(clock), .reset(reset), .f_valid(f_valid), .f_pc(f_pc),
        .f_instr(f_instr), .d_ready(d_ready), .flush(flush),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .a_ready(a_ready), .d_valid(d_valid), .d_pc(d_pc),
        .d_opcode(d_opcode), .d_op(d_op), .d_regA(d_regA),
        .d_regB(d_regB), .d_regD(d_regD), .d_dataA(d_dataA),
        .d_dataB(d_dataB), .d_imm(d_imm), .d_w_en(d_w_en),
        .d_illegal(d_illegal)
    );

    decode_stage #(.XLEN(32), .NREGS(32), .BYPASS_EN(0)) u_nb (
        .clock(clock), .reset(reset), .f_valid(f_valid), .f_pc(f_pc),
        .f_instr(f_instr), .d_ready(n_ready), .flush(flush),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .a_ready(a_ready), .d_valid(n_valid), .d_pc(n_pc),
        .d_opcode(n_opcode), .d_op(n_op), .d_regA(n_regA),
        .d_regB(n_regB), .d_regD(n_regD), .d_dataA(n_dataA),
        .d_dataB(n_dataB), .d_imm(n_imm), .d_w_en(n_w_en),
        .d_illegal(n_illegal)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] imm;
        logic        wen;
        logic        ill;
    } dec_t;

    function automatic logic [31:0] sx(input logic [31:0] v, input int n);
        if (v[n-1]) return v - (32'd1 << n);
        return v;
    endfunction

    function automatic dec_t dec(input logic [31:0] i);
        dec_t d;
        logic [2:0] f3;
        d = '0;
        f3 = i[14:12];
        case (i[6:0])
            7'h03, 7'h67: begin d.imm = sx(32'(i[31:20]), 12); d.wen = 1; end
            7'h13: begin
                d.imm = sx(32'(i[31:20]), 12);
                d.op = {(f3 == 3'd5) ? i[30] : 1'b0, f3};
                d.wen = 1;
            end
            7'h23: d.imm = sx(32'({i[31:25], i[11:7]}), 12);
            7'h63: begin
                d.imm = sx(32'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
                d.op = {1'b0, f3};
            end
            7'h37, 7'h17: begin d.imm = {i[31:12], 12'h000}; d.wen = 1; end
            7'h33: begin d.op = {i[30], f3}; d.wen = 1; end
            7'h6F: begin
                d.imm = sx(32'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
                d.wen = 1;
            end
            default: d.ill = 1;
        endcase
        if (i[11:7] == 5'd0) d.wen = 0;
        return d;
    endfunction

    // Model of the held instruction and the architectural registers
    logic        started = 1'b0;
    logic        m_valid;
    logic [31:0] m_pc, m_ins, m_da, m_db;
    logic [31:0] m_rf [32];

    function automatic logic [31:0] rd_reg(input logic [4:0] r);
        if (r == 0) return 0;
        if (wb_en && wb_reg == r) return wb_data;
        return m_rf[r];
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            started = 1'b1;
            m_valid = 0;
            m_pc = 0; m_ins = 0; m_da = 0; m_db = 0;
            for (int k = 0; k < 32; k++) m_rf[k] = 0;
        end else begin
            logic rdy;
            rdy = !m_valid || a_ready;
            if (flush) m_valid = 0;
            else if (f_valid && rdy) begin
                m_valid = 1;
                m_pc = f_pc;
                m_ins = f_instr;
                m_da = rd_reg(f_instr[19:15]);
                m_db = rd_reg(f_instr[24:20]);
            end else if (m_valid && a_ready) m_valid = 0;
            else if (m_valid && wb_en && wb_reg != 0) begin
                if (wb_reg == m_ins[19:15]) m_da = wb_data;
                if (wb_reg == m_ins[24:20]) m_db = wb_data;
            end
            if (wb_en && wb_reg != 0) m_rf[wb_reg] = wb_data;
        end
        #1;
        if (started) begin
            dec_t e;
            chk("m_valid", 32'(d_valid), 32'(m_valid));
            chk("m_ready", 32'(d_ready), 32'(!m_valid || a_ready));
            if (m_valid) begin
                e = dec(m_ins);
                chk("m_pc", d_pc, m_pc);
                chk("m_opcode", 32'(d_opcode), 32'(m_ins[6:0]));
                chk("m_op", 32'(d_op), 32'(e.op));
                chk("m_regA", 32'(d_regA), 32'(m_ins[19:15]));
                chk("m_regB", 32'(d_regB), 32'(m_ins[24:20]));
                chk("m_regD", 32'(d_regD), 32'(m_ins[11:7]));
                chk("m_dataA", d_dataA, m_da);
                chk("m_dataB", d_dataB, m_db);
                chk("m_imm", d_imm, e.imm);
                chk("m_w_en", 32'(d_w_en), 32'(e.wen));
                chk("m_illegal", 32'(d_illegal), 32'(e.ill));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic fetch(input logic v, input logic [31:0] pc,
                         input logic [31:0] ins);
        f_valid = v;
        f_pc = pc;
        f_instr = ins;
    endtask

    task automatic wb(input logic en, input logic [4:0] r,
                      input logic [31:0] d);
        wb_en = en;
        wb_reg = r;
        wb_data = d;
    endtask

    logic [31:0] tbl [10];

    initial begin
        tbl[0] = 32'h123453B7; tbl[1] = 32'hFFFFF417; tbl[2] = 32'h008000EF;
        tbl[3] = 32'hFE20AC23; tbl[4] = 32'h4031D213; tbl[5] = 32'h00412483;
        tbl[6] = 32'h00008067; tbl[7] = 32'h002081B3; tbl[8] = 32'h40208033;
        tbl[9] = 32'hFFFFFFFF;

        reset = 1; flush = 0; a_ready = 0;
        fetch(0, 0, 0);
        wb(0, 0, 0);
        tick(); tick();
        chk("rst_valid", 32'(d_valid), 0);
        chk("rst_pc", d_pc, 0);
        chk("rst_imm", d_imm, 0);
        chk("rst_ready", 32'(d_ready), 1);

        reset = 0; a_ready = 1;
        fetch(1, 32'h100, 32'h00500093);
        tick();
        chk("addi_valid", 32'(d_valid), 1);
        chk("addi_pc", d_pc, 32'h100);
        chk("addi_regD", 32'(d_regD), 1);
        chk("addi_imm", d_imm, 5);
        chk("addi_op", 32'(d_op), 0);
        chk("addi_w_en", 32'(d_w_en), 1);
        chk("addi_dataA", d_dataA, 0);

        fetch(1, 32'h104, 32'h002081B3);
        wb(1, 2, 32'hDEADBEEF);
        tick();
        chk("byp_dataB", d_dataB, 32'hDEADBEEF);
        chk("nobyp_dataB", n_dataB, 0);

        wb(0, 0, 0);
        fetch(1, 32'h108, 32'h00728313);
        tick();
        a_ready = 0;
        fetch(1, 32'h200, 32'h00500093);
        tick();
        chk("stall_ready", 32'(d_ready), 0);
        chk("stall_pc", d_pc, 32'h108);
        wb(1, 5, 32'h1234);
        tick();
        chk("stall_dataA", d_dataA, 32'h1234);
        chk("nobyp_stall_dataA", n_dataA, 0);
        wb(0, 0, 0);
        tick();
        chk("hold_pc", d_pc, 32'h108);
        chk("hold_imm", d_imm, 7);
        chk("hold_dataA", d_dataA, 32'h1234);

        a_ready = 1;
        fetch(1, 32'h10C, 32'hFE000EE3);
        tick();
        chk("beq_imm", d_imm, 32'hFFFFFFFC);
        chk("beq_op", 32'(d_op), 0);
        chk("beq_w_en", 32'(d_w_en), 0);
        fetch(1, 32'h110, 32'h40208033);
        tick();
        chk("sub_op", 32'(d_op), 32'h8);
        chk("sub_dataB", d_dataB, 32'hDEADBEEF);

        flush = 1;
        fetch(1, 32'h114, 32'h00500093);
        tick();
        chk("flush_valid", 32'(d_valid), 0);
        flush = 0;
        fetch(1, 32'h118, 32'hFFFFFFFF);
        tick();
        chk("ill_valid", 32'(d_valid), 1);
        chk("ill_flag", 32'(d_illegal), 1);
        chk("ill_w_en", 32'(d_w_en), 0);
        chk("ill_imm", d_imm, 0);

        fetch(0, 0, 0);
        wb(1, 0, 32'h55);
        tick();
        wb(0, 0, 0);
        fetch(1, 32'h11C, 32'h00500093);
        tick();
        chk("x0_dataA", d_dataA, 0);

        fetch(1, 32'h120, 32'h002081B3);
        tick();
        a_ready = 0;
        fetch(0, 0, 0);
        tick();
        chk("pre_rst_dataB", d_dataB, 32'hDEADBEEF);
        reset = 1;
        tick();
        chk("mid_rst_valid", 32'(d_valid), 0);
        chk("mid_rst_pc", d_pc, 0);
        reset = 0; a_ready = 1;
        fetch(1, 32'h124, 32'h002081B3);
        tick();
        chk("rf_clr_dataB", d_dataB, 0);

        for (int c = 0; c < 80; c++) begin
            fetch(($urandom % 4) != 0, 32'h300 + 32'(c * 4),
                  tbl[$urandom % 10]);
            a_ready = ($urandom % 3) != 0;
            flush = ($urandom % 16) == 0;
            wb(($urandom % 2) == 1, 5'($urandom % 10), $urandom);
            tick();
        end

        fetch(0, 0, 0);
        wb(0, 0, 0);
        flush = 0; a_ready = 1;
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
